// File: rtl/axis_instr_parser.sv
// Command front-end: parses 16-bit AXI-Stream command packets into data-mover instructions.
// Latency: parameters commit on the edge accepting w4; err_valid pulses the cycle after the offending word.
// Backpressure: tready is low during reset and while a committed instruction waits for its done.
module axis_instr_parser #(
  parameter logic [7:0] MAGIC       = 8'hA5,
  parameter logic [4:0] WR_BRAM_MAX = 5'd15,
  parameter logic [2:0] RD_BRAM_MAX = 3'd7
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [15:0] s_axis_cmd_tdata,
  input  logic        s_axis_cmd_tvalid,
  output logic        s_axis_cmd_tready,
  input  logic        s_axis_cmd_tlast,
  output logic [7:0]  Instruction_code,
  output logic [4:0]  wr_bram_start,
  output logic [4:0]  wr_bram_end,
  output logic [15:0] wr_addr_start,
  output logic [15:0] wr_addr_count,
  output logic [2:0]  rd_bram_start,
  output logic [2:0]  rd_bram_end,
  output logic [15:0] rd_addr_start,
  output logic [15:0] rd_addr_count,
  input  logic        write_done,
  input  logic        read_done,
  output logic        busy,
  output logic        cmd_accepted,
  output logic        err_valid,
  output logic [1:0]  err_code,
  output logic [7:0]  err_count
);

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;

  localparam logic [1:0] ERR_HDR = 2'd1;
  localparam logic [1:0] ERR_LEN = 2'd2;
  localparam logic [1:0] ERR_RNG = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PARAM = 2'd1,
    S_EXEC  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_nxt_state;

  // Shadow copy of the packet being collected; only copied to outputs on commit.
  logic        r_is_read;
  logic [2:0]  r_idx;
  logic        r_rng_bad;
  logic [4:0]  r_sh_bram_start;
  logic [4:0]  r_sh_bram_end;
  logic [15:0] r_sh_addr_start;

  logic        w_hs;
  logic        w_hdr_ok;
  logic [7:0]  w_opcode;
  logic        w_field_bad;
  logic [4:0]  w_bram_max;
  logic        w_params_ok;
  logic        w_commit;
  logic        w_done;
  logic        w_err;
  logic [1:0]  w_err_code;

  assign w_hs        = s_axis_cmd_tvalid & s_axis_cmd_tready;
  assign w_opcode    = s_axis_cmd_tdata[7:0];
  assign w_hdr_ok    = (s_axis_cmd_tdata[15:8] == MAGIC) &&
                       ((w_opcode == OP_NOP) || (w_opcode == OP_WRITE) || (w_opcode == OP_READ));
  // Any set bit above the BRAM index width of the current direction is out of range.
  assign w_field_bad = r_is_read ? (s_axis_cmd_tdata[15:3] != 13'd0)
                                 : (s_axis_cmd_tdata[15:5] != 11'd0);
  assign w_bram_max  = r_is_read ? {2'b00, RD_BRAM_MAX} : WR_BRAM_MAX;
  // Evaluated while w4 (addr_count) is on the bus.
  assign w_params_ok = !r_rng_bad &&
                       (r_sh_bram_start <= r_sh_bram_end) &&
                       (r_sh_bram_end <= w_bram_max) &&
                       (s_axis_cmd_tdata != 16'd0);

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nxt_state;
    end
  end

  // Next-state decode plus the commit/done/error strobes and tready.
  always_comb begin
    w_nxt_state       = r_state;
    w_commit          = 1'b0;
    w_done            = 1'b0;
    w_err             = 1'b0;
    w_err_code        = 2'd0;
    s_axis_cmd_tready = aresetn && (r_state != S_EXEC);
    case (r_state)
      S_IDLE: begin
        if (w_hs) begin
          if (!w_hdr_ok) begin
            w_err       = 1'b1;
            w_err_code  = ERR_HDR;
            w_nxt_state = s_axis_cmd_tlast ? S_IDLE : S_DRAIN;
          end else if (w_opcode == OP_NOP) begin
            if (!s_axis_cmd_tlast) begin
              w_err       = 1'b1;
              w_err_code  = ERR_LEN;
              w_nxt_state = S_DRAIN;
            end
          end else if (s_axis_cmd_tlast) begin
            w_err      = 1'b1;
            w_err_code = ERR_LEN;
          end else begin
            w_nxt_state = S_PARAM;
          end
        end
      end
      S_PARAM: begin
        if (w_hs) begin
          if (r_idx != 3'd4) begin
            if (s_axis_cmd_tlast) begin
              w_err       = 1'b1;
              w_err_code  = ERR_LEN;
              w_nxt_state = S_IDLE;
            end
          end else if (!s_axis_cmd_tlast) begin
            w_err       = 1'b1;
            w_err_code  = ERR_LEN;
            w_nxt_state = S_DRAIN;
          end else if (w_params_ok) begin
            w_commit    = 1'b1;
            w_nxt_state = S_EXEC;
          end else begin
            w_err       = 1'b1;
            w_err_code  = ERR_RNG;
            w_nxt_state = S_IDLE;
          end
        end
      end
      S_EXEC: begin
        if (r_is_read ? read_done : write_done) begin
          w_done      = 1'b1;
          w_nxt_state = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (w_hs && s_axis_cmd_tlast) begin
          w_nxt_state = S_IDLE;
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  // Collect the packet fields word by word into the shadow registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_is_read       <= 1'b0;
      r_idx           <= 3'd0;
      r_rng_bad       <= 1'b0;
      r_sh_bram_start <= 5'd0;
      r_sh_bram_end   <= 5'd0;
      r_sh_addr_start <= 16'd0;
    end else if (w_hs) begin
      if (r_state == S_IDLE) begin
        r_is_read <= (w_opcode == OP_READ);
        r_idx     <= 3'd1;
        r_rng_bad <= 1'b0;
      end else if (r_state == S_PARAM) begin
        r_idx <= r_idx + 3'd1;
        case (r_idx)
          3'd1: begin
            r_sh_bram_start <= s_axis_cmd_tdata[4:0];
            r_rng_bad       <= r_rng_bad | w_field_bad;
          end
          3'd2: begin
            r_sh_bram_end <= s_axis_cmd_tdata[4:0];
            r_rng_bad     <= r_rng_bad | w_field_bad;
          end
          3'd3: r_sh_addr_start <= s_axis_cmd_tdata;
          default: ;
        endcase
      end
    end
  end

  // Committed instruction outputs; only the active direction is overwritten.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      Instruction_code <= 8'h00;
      wr_bram_start    <= 5'd0;
      wr_bram_end      <= 5'd0;
      wr_addr_start    <= 16'd0;
      wr_addr_count    <= 16'd0;
      rd_bram_start    <= 3'd0;
      rd_bram_end      <= 3'd0;
      rd_addr_start    <= 16'd0;
      rd_addr_count    <= 16'd0;
      busy             <= 1'b0;
      cmd_accepted     <= 1'b0;
    end else begin
      cmd_accepted <= w_commit;
      if (w_commit) begin
        busy <= 1'b1;
        if (r_is_read) begin
          Instruction_code <= OP_READ;
          rd_bram_start    <= r_sh_bram_start[2:0];
          rd_bram_end      <= r_sh_bram_end[2:0];
          rd_addr_start    <= r_sh_addr_start;
          rd_addr_count    <= s_axis_cmd_tdata;
        end else begin
          Instruction_code <= OP_WRITE;
          wr_bram_start    <= r_sh_bram_start;
          wr_bram_end      <= r_sh_bram_end;
          wr_addr_start    <= r_sh_addr_start;
          wr_addr_count    <= s_axis_cmd_tdata;
        end
      end else if (w_done) begin
        Instruction_code <= 8'h00;
        busy             <= 1'b0;
      end
    end
  end

  // Error pulse, sticky last-error code and saturating reject counter.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      err_valid <= 1'b0;
      err_code  <= 2'd0;
      err_count <= 8'd0;
    end else begin
      err_valid <= w_err;
      if (w_err) begin
        err_code <= w_err_code;
        if (err_count != 8'hFF) begin
          err_count <= err_count + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_instr_parser.sv
// Directed bench for axis_instr_parser with hand-computed expectations.
// Inputs are driven and outputs sampled on the falling edge of aclk.
// tready is honoured with a bounded wait on every word.
module tb_axis_instr_parser;

  logic        aclk;
  logic        aresetn;
  logic [15:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic [7:0]  instr;
  logic [4:0]  wr_bs, wr_be;
  logic [15:0] wr_as, wr_ac;
  logic [2:0]  rd_bs, rd_be;
  logic [15:0] rd_as, rd_ac;
  logic        write_done, read_done;
  logic        busy, cmd_accepted, err_valid;
  logic [1:0]  err_code;
  logic [7:0]  err_count;

  int n_tests = 0;
  int n_fail  = 0;
  int n_err_pulses = 0;
  int n_acc_pulses = 0;
  int e0, a0;

  axis_instr_parser dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .s_axis_cmd_tdata  (tdata),
    .s_axis_cmd_tvalid (tvalid),
    .s_axis_cmd_tready (tready),
    .s_axis_cmd_tlast  (tlast),
    .Instruction_code  (instr),
    .wr_bram_start     (wr_bs),
    .wr_bram_end       (wr_be),
    .wr_addr_start     (wr_as),
    .wr_addr_count     (wr_ac),
    .rd_bram_start     (rd_bs),
    .rd_bram_end       (rd_be),
    .rd_addr_start     (rd_as),
    .rd_addr_count     (rd_ac),
    .write_done        (write_done),
    .read_done         (read_done),
    .busy              (busy),
    .cmd_accepted      (cmd_accepted),
    .err_valid         (err_valid),
    .err_code          (err_code),
    .err_count         (err_count)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Count strobe pulses, sampled on the rising edge (sees the previous cycle's value).
  always @(posedge aclk) begin
    if (err_valid)    n_err_pulses <= n_err_pulses + 1;
    if (cmd_accepted) n_acc_pulses <= n_acc_pulses + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_word(input logic [15:0] d, input logic l);
    int w;
    @(negedge aclk);
    tdata  = d;
    tlast  = l;
    tvalid = 1'b1;
    w = 0;
    while (!tready && w < 50) begin
      @(negedge aclk);
      w++;
    end
    if (!tready) check("tready_timeout", 32'(tready), 32'd1);
    @(posedge aclk);
  endtask

  task automatic end_pkt();
    @(negedge aclk);
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic pkt5(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                      input logic [15:0] w3, input logic [15:0] w4);
    send_word(w0, 1'b0);
    send_word(w1, 1'b0);
    send_word(w2, 1'b0);
    send_word(w3, 1'b0);
    send_word(w4, 1'b1);
    end_pkt();
  endtask

  task automatic pulse_wd();
    @(negedge aclk);
    write_done = 1'b1;
    @(negedge aclk);
    write_done = 1'b0;
  endtask

  task automatic pulse_rd();
    @(negedge aclk);
    read_done = 1'b1;
    @(negedge aclk);
    read_done = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge aclk);
  endtask

  initial begin
    aresetn    = 1'b0;
    tdata      = 16'h0;
    tvalid     = 1'b0;
    tlast      = 1'b0;
    write_done = 1'b0;
    read_done  = 1'b0;

    // Reset state
    idle(3);
    check("rst_tready", 32'(tready), 32'd0);
    check("rst_instr", 32'(instr), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_errcnt", 32'(err_count), 32'd0);
    check("rst_errcode", 32'(err_code), 32'd0);
    aresetn = 1'b1;
    idle(1);
    check("post_rst_tready", 32'(tready), 32'd1);

    // Valid WRITE
    pkt5(16'hA501, 16'h0000, 16'h000F, 16'h0000, 16'h0200);
    check("wr_instr", 32'(instr), 32'h01);
    check("wr_bs", 32'(wr_bs), 32'd0);
    check("wr_be", 32'(wr_be), 32'd15);
    check("wr_as", 32'(wr_as), 32'd0);
    check("wr_ac", 32'(wr_ac), 32'd512);
    check("wr_acc", 32'(cmd_accepted), 32'd1);
    check("wr_busy", 32'(busy), 32'd1);
    check("wr_tready", 32'(tready), 32'd0);
    idle(1);
    check("wr_acc_pulse", 32'(cmd_accepted), 32'd0);
    pulse_wd();
    check("wr_done_instr", 32'(instr), 32'h00);
    check("wr_done_busy", 32'(busy), 32'd0);
    check("wr_done_tready", 32'(tready), 32'd1);

    // Valid READ, write_done ignored
    pkt5(16'hA502, 16'h0002, 16'h0005, 16'h0010, 16'h0040);
    check("rd_instr", 32'(instr), 32'h02);
    check("rd_bs", 32'(rd_bs), 32'd2);
    check("rd_be", 32'(rd_be), 32'd5);
    check("rd_as", 32'(rd_as), 32'h10);
    check("rd_ac", 32'(rd_ac), 32'h40);
    check("rd_keep_wr_be", 32'(wr_be), 32'd15);
    check("rd_keep_wr_ac", 32'(wr_ac), 32'd512);
    pulse_wd();
    check("rd_ignore_wd", 32'(instr), 32'h02);
    check("rd_ignore_wd_busy", 32'(busy), 32'd1);
    pulse_rd();
    check("rd_done_instr", 32'(instr), 32'h00);
    check("rd_done_tready", 32'(tready), 32'd1);

    // Bad magic, drained
    e0 = n_err_pulses; a0 = n_acc_pulses;
    pkt5(16'h5A01, 16'h0000, 16'h000F, 16'h0000, 16'h0200);
    idle(2);
    check("bm_errpulse", 32'(n_err_pulses - e0), 32'd1);
    check("bm_errcode", 32'(err_code), 32'd1);
    check("bm_errcnt", 32'(err_count), 32'd1);
    check("bm_nocommit", 32'(n_acc_pulses - a0), 32'd0);
    check("bm_instr", 32'(instr), 32'h00);
    check("bm_tready", 32'(tready), 32'd1);

    // Range errors
    pkt5(16'hA502, 16'h0000, 16'h0008, 16'h0000, 16'h0001);
    check("rng_end8_code", 32'(err_code), 32'd3);
    check("rng_end8_cnt", 32'(err_count), 32'd2);
    check("rng_end8_instr", 32'(instr), 32'h00);
    pkt5(16'hA502, 16'h0005, 16'h0002, 16'h0000, 16'h0001);
    check("rng_order_cnt", 32'(err_count), 32'd3);
    pkt5(16'hA502, 16'h0000, 16'h0001, 16'h0000, 16'h0000);
    check("rng_cnt0_ev", 32'(err_valid), 32'd1);
    check("rng_cnt0_code", 32'(err_code), 32'd3);
    check("rng_cnt0_cnt", 32'(err_count), 32'd4);
    pkt5(16'hA501, 16'h0020, 16'h0001, 16'h0000, 16'h0001);
    check("rng_hibit_cnt", 32'(err_count), 32'd5);
    check("rng_hibit_busy", 32'(busy), 32'd0);

    // Length error: tlast on w2, then a valid WRITE with done in the commit cycle
    send_word(16'hA502, 1'b0);
    send_word(16'h0001, 1'b0);
    send_word(16'h0002, 1'b1);
    end_pkt();
    check("len_w2_ev", 32'(err_valid), 32'd1);
    check("len_w2_code", 32'(err_code), 32'd2);
    check("len_w2_cnt", 32'(err_count), 32'd6);
    send_word(16'hA501, 1'b0);
    send_word(16'h0003, 1'b0);
    send_word(16'h0004, 1'b0);
    send_word(16'h1234, 1'b0);
    write_done = 1'b1;
    send_word(16'h0010, 1'b1);
    end_pkt();
    write_done = 1'b0;
    check("len_next_instr", 32'(instr), 32'h01);
    check("len_next_busy", 32'(busy), 32'd1);
    check("len_next_wr", {wr_bs, wr_be, 6'd0, wr_as}, {5'd3, 5'd4, 6'd0, 16'h1234});
    check("len_next_ac", 32'(wr_ac), 32'h10);
    check("len_next_keep_rd", {13'd0, rd_bs, rd_ac}, {13'd0, 3'd2, 16'h0040});
    check("len_next_errcode", 32'(err_code), 32'd2);
    idle(1);
    check("done_in_commit_ignored", 32'(busy), 32'd1);
    pulse_wd();
    check("len_next_done", 32'(instr), 32'h00);

    // 6-word packet: error at w4, drained to w5
    send_word(16'hA501, 1'b0);
    send_word(16'h0000, 1'b0);
    send_word(16'h0001, 1'b0);
    send_word(16'h0000, 1'b0);
    send_word(16'h0005, 1'b0);
    send_word(16'h0006, 1'b1);
    end_pkt();
    check("len6_code", 32'(err_code), 32'd2);
    check("len6_cnt", 32'(err_count), 32'd7);
    check("len6_tready", 32'(tready), 32'd1);
    check("len6_instr", 32'(instr), 32'h00);

    // NOP with tlast: no commit, no error
    e0 = n_err_pulses; a0 = n_acc_pulses;
    send_word(16'hA500, 1'b1);
    end_pkt();
    idle(2);
    check("nop_cnt", 32'(err_count), 32'd7);
    check("nop_errpulse", 32'(n_err_pulses - e0), 32'd0);
    check("nop_acc", 32'(n_acc_pulses - a0), 32'd0);
    check("nop_tready", 32'(tready), 32'd1);

    // Asynchronous reset mid-PARAM
    send_word(16'hA501, 1'b0);
    send_word(16'h0001, 1'b0);
    #2;
    aresetn = 1'b0;
    tvalid  = 1'b0;
    #1;
    check("arst_p_cnt", 32'(err_count), 32'd0);
    check("arst_p_code", 32'(err_code), 32'd0);
    check("arst_p_wr_be", 32'(wr_be), 32'd0);
    check("arst_p_rd_ac", 32'(rd_ac), 32'd0);
    check("arst_p_tready", 32'(tready), 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    pkt5(16'hA501, 16'h0001, 16'h0002, 16'h0100, 16'h0008);
    check("arst_recover", {instr, 3'd0, wr_bs, wr_ac}, {8'h01, 3'd0, 5'd1, 16'h0008});
    // Asynchronous reset mid-EXEC
    #2;
    aresetn = 1'b0;
    #1;
    check("arst_e_instr", 32'(instr), 32'h00);
    check("arst_e_busy", 32'(busy), 32'd0);
    check("arst_e_wr_ac", 32'(wr_ac), 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    idle(1);
    check("arst_e_tready", 32'(tready), 32'd1);

    // Saturation of err_count
    for (int i = 0; i < 300; i++) begin
      send_word(16'h5A00, 1'b1);
    end
    end_pkt();
    check("sat_cnt", 32'(err_count), 32'd255);
    check("sat_code", 32'(err_code), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

endmodule

// File: doc/axis_instr_parser.md
# axis_instr_parser

Command front-end for the BRAM data-mover. It consumes fixed-format 16-bit command packets on a dedicated AXI-Stream slave, validates them, and drives the instruction and write/read range parameters into the data-mover FSM. It holds each committed instruction until the data mover reports the matching batch-done, then returns to accepting commands. Malformed packets are drained and reported without disturbing the data path.

## Interface
Parameters:
- `MAGIC`, 8'hA5: required value of word0[15:8].
- `WR_BRAM_MAX`, 15: highest legal write BRAM index.
- `RD_BRAM_MAX`, 7: highest legal read BRAM index.

Ports:
- `aclk`  in  1  single clock; all logic is on the rising edge.
- `aresetn`  in  1  **asynchronous, active-low reset**.
- `s_axis_cmd_tdata`  in  16  command word.
- `s_axis_cmd_tvalid`  in  1  command word valid.
- `s_axis_cmd_tready`  out  1  parser accepts a word.
- `s_axis_cmd_tlast`  in  1  last word of the packet.
- `Instruction_code`  out  8  committed opcode; 8'h00 when idle.
- `wr_bram_start`, `wr_bram_end`  out  5 each  committed write BRAM range.
- `wr_addr_start`, `wr_addr_count`  out  16 each  committed write address range.
- `rd_bram_start`, `rd_bram_end`  out  3 each  committed read BRAM range.
- `rd_addr_start`, `rd_addr_count`  out  16 each  committed read address range.
- `write_done`, `read_done`  in  1 each  batch-done pulses from the data mover.
- `busy`  out  1  an instruction is committed and awaiting done.
- `cmd_accepted`  out  1  one-cycle pulse on commit.
- `err_valid`  out  1  one-cycle pulse when a packet is rejected.
- `err_code`  out  2  last error: 0 none, 1 bad magic/opcode, 2 length, 3 range.
- `err_count`  out  8  rejected packets, saturating at 255.

## Operation
- Packet word0: [15:8] must equal MAGIC; [7:0] is the opcode, one of 8'h00 NOP, 8'h01 WRITE, 8'h02 READ.
- NOP is exactly 1 word. tlast on word0 is accepted and ignored: no commit and no error.
- WRITE and READ are exactly 5 words:
  - w1 = bram_start in [4:0]
  - w2 = bram_end in [4:0]
  - w3 = addr_start
  - w4 = addr_count, with tlast on w4.
- For READ, the BRAM fields use [2:0]. In both opcodes, any nonzero bit above the field width is a range error.
- Parameters are collected in shadow registers. Output registers update only at commit, all in the same cycle. The opposite-direction outputs keep their previous values.
- Validation at w4:
  - start ≤ end
  - end ≤ WR_BRAM_MAX for WRITE, ≤ RD_BRAM_MAX for READ
  - addr_count ≠ 0
  - Any failure is a range error (code 3).
- States:
  - IDLE: tready=1. On a word0 handshake:
    - bad magic or unknown opcode → error code 1; go to IDLE if tlast, else DRAIN.
    - NOP with tlast → stay IDLE. NOP without tlast → error code 2, DRAIN.
    - WRITE/READ with tlast → error code 2, IDLE.
    - otherwise → PARAM with idx=1.
  - PARAM: tready=1; idx counts 1..4.
    - tlast before w4 → error code 2, IDLE.
    - w4 without tlast → error code 2, DRAIN.
    - w4 with tlast and valid → commit, EXEC.
    - w4 with tlast and invalid → error code 3, IDLE.
  - EXEC: tready=0, busy=1. WRITE waits for write_done; READ waits for read_done; the other done input is ignored. On the matching done → Instruction_code←8'h00, IDLE.
  - DRAIN: tready=1. Discard words until the tlast handshake, then IDLE.
- Error reporting: err_valid pulses the cycle after the offending handshake. err_code holds until the next error; a commit does not clear it. err_count increments by 1 per rejected packet.

## Timing
- Reset values: tready=0 during reset; every output, state and counter is 0. Instruction_code=8'h00; err_code=0.
- First cycle after reset release: tready=1 (state IDLE).
- Commit latency: outputs, cmd_accepted and busy change on the edge that accepts w4, so they are visible 1 cycle after that handshake.
- Done to idle: the edge sampling the matching done in EXEC clears Instruction_code and busy. tready is 1 the following cycle. A done asserted in the commit cycle itself is not sampled.
- Throughput: one word per cycle while tvalid=1. Minimum of 1 idle cycle (the EXEC cycle) between consecutive WRITE/READ packets.
- Reset asserted mid-packet or mid-EXEC: everything clears asynchronously and the partial packet is lost. The upstream must restart at word0.

## Test plan
- Valid WRITE A501,0000,000F,0000,0200(tlast) → next cycle Instruction_code=01, wr 0..15, addr 0, count 512, cmd_accepted=1, tready=0. write_done pulse → Instruction_code=00, then tready=1.
- Valid READ A502,0002,0005,0010,0040(tlast) → rd_bram 2..5, start 16, count 64. A write_done pulse is ignored. read_done → idle. Write outputs are unchanged from the previous command.
- Bad magic 5A01 followed by 4 words, tlast on the last → err_valid=1, err_code=1, err_count=1. All words are drained and no commit occurs.
- READ with rd_bram_end=0008 → err_code=3, no commit. READ with start 5, end 2 → err_code=3. addr_count=0 → err_code=3.
- Length errors: tlast on w2 → err_code=2, back to IDLE, and the next valid packet commits normally. A 6-word packet with tlast on w5 → err_code=2 after drain. NOP A500(tlast) → no change and no error.
- Assert aresetn=0 asynchronously mid-PARAM and mid-EXEC → all outputs are 0 immediately. After release, a full valid packet commits correctly. err_count saturates at 255 after 300 bad packets.
